// File: rtl/scan_select_sequencer.sv
// Channel-index sequencer feeding the 3-to-8 one-hot decoder.
// Walks the enabled channels in ascending order and holds each one for dwell+1 cycles.
module scan_select_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [7:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               chan_adv,
    output logic               pass_done,
    output logic               busy
);

    typedef enum logic {StIdle, StScan} state_e;

    localparam logic [DWELL_W-1:0] CntZero = '0;
    localparam logic [DWELL_W-1:0] CntOne  = DWELL_W'(1);

    state_e             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               chan_adv_q, chan_adv_d;
    logic               pass_done_q, pass_done_d;
    logic               busy_q, busy_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         mask_q, mask_d;
    logic               mode_q, mode_d;

    // Lowest set bit of m; callers only rely on the result when m != 0.
    function automatic logic [2:0] lowest_idx(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Enabled channels strictly above cur; the 8-bit shift drops to zero for cur=7.
    function automatic logic [7:0] above(input logic [7:0] m, input logic [2:0] cur);
        logic [7:0] at_or_below;
        at_or_below = (8'd2 << cur) - 8'd1;
        return m & ~at_or_below;
    endfunction

    logic [7:0] higher_q;
    assign higher_q = above(mask_q, sel_q);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        dwell_d     = dwell_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        chan_adv_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop && (chan_mask != 8'h00)) begin
                    mask_d     = chan_mask;
                    dwell_d    = dwell;
                    mode_d     = mode_cont;
                    sel_d      = lowest_idx(chan_mask);
                    cnt_d      = CntZero;
                    chan_adv_d = 1'b1;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (stop) begin
                    state_d = StIdle;
                    cnt_d   = CntZero;
                end else if (cnt_q == dwell_q) begin
                    cnt_d = CntZero;
                    if (higher_q != 8'h00) begin
                        sel_d      = lowest_idx(higher_q);
                        chan_adv_d = 1'b1;
                    end else if (mode_q) begin
                        sel_d      = lowest_idx(mask_q);
                        chan_adv_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        sel_valid_d = (state_d == StScan);
        busy_d      = (state_d == StScan);
        // Registered one cycle ahead: flags the final hold cycle of the last enabled channel.
        pass_done_d = (state_d == StScan) && (cnt_d == dwell_d)
                      && (above(mask_d, sel_d) == 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sel_q       <= 3'd0;
            sel_valid_q <= 1'b0;
            chan_adv_q  <= 1'b0;
            pass_done_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= CntZero;
            dwell_q     <= CntZero;
            mask_q      <= 8'h00;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            chan_adv_q  <= chan_adv_d;
            pass_done_q <= pass_done_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign chan_adv  = chan_adv_q;
    assign pass_done = pass_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Scoreboard bench for scan_select_sequencer: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against {sel_valid, busy, sel, chan_adv, pass_done}.
module tb_scan_select_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode_cont = 1'b0;
    logic [7:0] chan_mask = 8'h00;
    logic [7:0] dwell = 8'h00;
    logic [2:0] sel;
    logic       sel_valid;
    logic       chan_adv;
    logic       pass_done;
    logic       busy;

    scan_select_sequencer #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode_cont (mode_cont),
        .chan_mask (chan_mask),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .chan_adv  (chan_adv),
        .pass_done (pass_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] v;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {v,b,sel,adv,pd}=%b_%b_%0d_%b_%b expected %b_%b_%0d_%b_%b",
                     name, act[6], act[5], act[4:2], act[1], act[0],
                     exp[6], exp[5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Wait for the next active edge, then queue what the outputs must show in that cycle.
    task automatic tick(input string name, input logic v, input logic b, input logic [2:0] s,
                        input logic a, input logic p);
        exp_t e;
        @(posedge clk);
        #1;
        e.v    = {v, b, s, a, p};
        e.name = name;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check(e.name, {sel_valid, busy, sel, chan_adv, pass_done}, e.v);
        end
    end

    initial begin
        // Reset state, checked while reset is held
        #2;
        check("reset_state", {sel_valid, busy, sel, chan_adv, pass_done}, 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick("idle_after_reset", 0, 0, 3'd0, 0, 0);
        tick("idle_after_reset", 0, 0, 3'd0, 0, 0);

        // Reset mid-scan while sel=5
        chan_mask = 8'h20; dwell = 8'd5; mode_cont = 1'b1; start = 1'b1;
        tick("rst_scan_start", 1, 1, 3'd5, 1, 0);
        start = 1'b0;
        tick("rst_scan_hold", 1, 1, 3'd5, 0, 0);
        tick("rst_scan_hold", 1, 1, 3'd5, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", {sel_valid, busy, sel, chan_adv, pass_done}, 7'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick("rst_no_activity", 0, 0, 3'd0, 0, 0);

        // Single pass over all channels, dwell=2
        chan_mask = 8'hFF; dwell = 8'd2; mode_cont = 1'b0; start = 1'b1;
        for (int ch = 0; ch < 8; ch++) begin
            for (int k = 0; k < 3; k++) begin
                tick("single_pass", 1, 1, 3'(ch), (k == 0), (ch == 7 && k == 2));
                start = 1'b0;
            end
        end
        tick("single_pass_end", 0, 0, 3'd7, 0, 0);
        tick("single_pass_end", 0, 0, 3'd7, 0, 0);

        // Sparse mask, dwell=0, continuous wrap
        chan_mask = 8'b1010_0100; dwell = 8'd0; mode_cont = 1'b1; start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick("sparse_wrap", 1, 1, 3'd2, 1, 0);
            start = 1'b0;
            tick("sparse_wrap", 1, 1, 3'd5, 1, 0);
            tick("sparse_wrap", 1, 1, 3'd7, 1, 1);
        end
        stop = 1'b1;
        tick("sparse_stop", 0, 0, 3'd7, 0, 0);
        stop = 1'b0;

        // Stop on the 4th cycle of sel=1
        chan_mask = 8'h0F; dwell = 8'd9; mode_cont = 1'b0; start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick("stop_mid_ch0", 1, 1, 3'd0, (k == 0), 0);
            start = 1'b0;
        end
        for (int k = 0; k < 4; k++) tick("stop_mid_ch1", 1, 1, 3'd1, (k == 0), 0);
        stop = 1'b1;
        tick("stop_mid_idle", 0, 0, 3'd1, 0, 0);
        stop = 1'b0;
        for (int i = 0; i < 3; i++) tick("stop_mid_stays", 0, 0, 3'd1, 0, 0);

        // Ignored controls
        chan_mask = 8'h00; start = 1'b1;
        tick("start_mask0", 0, 0, 3'd1, 0, 0);
        chan_mask = 8'hFF; stop = 1'b1;
        tick("start_and_stop", 0, 0, 3'd1, 0, 0);
        stop = 1'b0;
        chan_mask = 8'hF0; dwell = 8'd1; mode_cont = 1'b0;
        for (int ch = 4; ch < 8; ch++) begin
            for (int k = 0; k < 2; k++) begin
                tick("ignored_ctrl", 1, 1, 3'(ch), (k == 0), (ch == 7 && k == 1));
                chan_mask = 8'h01;
                dwell     = 8'd7;
                mode_cont = 1'b1;
                start     = (ch == 5);
            end
        end
        start = 1'b0;
        tick("ignored_ctrl_end", 0, 0, 3'd7, 0, 0);

        // Single channel, continuous
        chan_mask = 8'h08; dwell = 8'd3; mode_cont = 1'b1; start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                tick("single_ch_cont", 1, 1, 3'd3, (k == 0), (k == 3));
                start = 1'b0;
            end
        end
        stop = 1'b1;
        tick("single_ch_stop", 0, 0, 3'd3, 0, 0);
        stop = 1'b0;
        tick("single_ch_idle", 0, 0, 3'd3, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
